// File: rtl/nec_ir_tx.sv
// -----------------------------------------------------------------------------
// nec_ir_tx
//   NEC infrared frame transmitter. Serialises an 8-bit address and an 8-bit
//   command into an NEC pulse train, or sends an NEC repeat code. Drives the
//   board IR LED and feeds the IR receive path for loopback self-test.
//
//   Frame: 16T lead mark, 8T lead space (4T for a repeat code), then for a
//   full frame 32 bits {~command, command, ~address, address} LSB first, each
//   a 1T mark followed by a 1T (bit 0) or 3T (bit 1) space, then a 1T stop
//   mark and a GAP_UNITS*T idle gap.
//
// Parameters
//   UNIT_CYCLES  clk cycles per NEC base unit T (>= 2)
//   GAP_UNITS    idle units after the stop mark before busy_o drops (>= 1)
//   CARRIER_DIV  clk cycles per carrier half-period (carrier build only)
//
// Configuration
//   NEC_TX_CARRIER_EN  when defined, marks are modulated with a carrier that
//                      toggles every CARRIER_DIV clocks and restarts high on
//                      entry to each mark; spaces stay 0. When undefined,
//                      ir_o is the plain envelope. Timing is identical.
//
// Ports
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   start_i    transmit request, sampled only in IDLE
//   repeat_i   sampled with start_i: 1 = repeat code, 0 = full frame
//   address_i  NEC address, latched when start is accepted
//   command_i  NEC command, latched when start is accepted
//   busy_o     high from start acceptance until the gap ends
//   done_o     one-cycle pulse on the edge where busy_o falls
//   ir_o       1 = mark (LED on), 0 = space
//   state_o    current FSM state (debug observation)
//
// Handshake: start_i is a request and ~busy_o is the ready. A request is
// taken on any edge where the FSM is in IDLE and start_i=1; requests while
// busy (including the edge on which busy_o falls) are dropped, not queued.
// -----------------------------------------------------------------------------
module nec_ir_tx #(
    parameter int UNIT_CYCLES = 28125,
    parameter int GAP_UNITS   = 16,
    parameter int CARRIER_DIV = 658
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       repeat_i,
    input  logic [7:0] address_i,
    input  logic [7:0] command_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       ir_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5,
        GAP        = 3'd6
    } state_t;

`ifdef NEC_TX_CARRIER_EN
    localparam bit CARRIER_ON = 1'b1;
`else
    localparam bit CARRIER_ON = 1'b0;
`endif

    // The longest state is either the 16T lead mark or the gap.
    localparam int LONGEST_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int CNT_W         = $clog2(LONGEST_UNITS * UNIT_CYCLES);
    localparam int CAR_W         = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [CAR_W-1:0] CAR_LOAD = CAR_W'(CARRIER_DIV - 1);

    // Reload value for a state lasting n units: the counter runs n*T-1 down
    // to 0 and the state changes on the edge where it reads 0.
    function automatic logic [CNT_W-1:0] units(input int n);
        return CNT_W'(n * UNIT_CYCLES - 1);
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   unit_cnt;
    logic [5:0]         bit_cnt;
    logic [7:0]         addr_q;
    logic [7:0]         cmd_q;
    logic               rep_q;
    logic [CAR_W-1:0]   car_cnt;

    logic [31:0]        payload;
    logic               cur_bit;
    logic               in_mark;

    assign payload = {~cmd_q, cmd_q, ~addr_q, addr_q};
    assign cur_bit = payload[bit_cnt[4:0]];
    assign in_mark = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
    assign state_o = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            unit_cnt <= '0;
            bit_cnt  <= '0;
            addr_q   <= '0;
            cmd_q    <= '0;
            rep_q    <= 1'b0;
            car_cnt  <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            ir_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;

            // Every mark entry sets ir_o high and restarts the carrier phase;
            // every space entry sets ir_o low.
            case (state)
                IDLE: begin
                    if (start_i) begin
                        addr_q   <= address_i;
                        cmd_q    <= command_i;
                        rep_q    <= repeat_i;
                        state    <= LEAD_MARK;
                        unit_cnt <= units(16);
                        busy_o   <= 1'b1;
                        ir_o     <= 1'b1;
                        car_cnt  <= CAR_LOAD;
                    end
                end

                LEAD_MARK: begin
                    if (unit_cnt == '0) begin
                        state    <= LEAD_SPACE;
                        unit_cnt <= rep_q ? units(4) : units(8);
                        ir_o     <= 1'b0;
                    end else begin
                        unit_cnt <= unit_cnt - 1'b1;
                    end
                end

                LEAD_SPACE: begin
                    if (unit_cnt == '0) begin
                        state    <= rep_q ? STOP_MARK : BIT_MARK;
                        unit_cnt <= units(1);
                        bit_cnt  <= '0;
                        ir_o     <= 1'b1;
                        car_cnt  <= CAR_LOAD;
                    end else begin
                        unit_cnt <= unit_cnt - 1'b1;
                    end
                end

                BIT_MARK: begin
                    if (unit_cnt == '0) begin
                        state    <= BIT_SPACE;
                        unit_cnt <= cur_bit ? units(3) : units(1);
                        ir_o     <= 1'b0;
                    end else begin
                        unit_cnt <= unit_cnt - 1'b1;
                    end
                end

                BIT_SPACE: begin
                    if (unit_cnt == '0) begin
                        if (bit_cnt == 6'd31) begin
                            state <= STOP_MARK;
                        end else begin
                            state   <= BIT_MARK;
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                        unit_cnt <= units(1);
                        ir_o     <= 1'b1;
                        car_cnt  <= CAR_LOAD;
                    end else begin
                        unit_cnt <= unit_cnt - 1'b1;
                    end
                end

                STOP_MARK: begin
                    if (unit_cnt == '0) begin
                        state    <= GAP;
                        unit_cnt <= units(GAP_UNITS);
                        ir_o     <= 1'b0;
                    end else begin
                        unit_cnt <= unit_cnt - 1'b1;
                    end
                end

                GAP: begin
                    if (unit_cnt == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        unit_cnt <= unit_cnt - 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    unit_cnt <= '0;
                    busy_o   <= 1'b0;
                    ir_o     <= 1'b0;
                end
            endcase

            // Carrier inside a mark that is not ending this cycle. Mark exits
            // (counter at 0) are left to the state logic above.
            if (CARRIER_ON && in_mark && (unit_cnt != '0)) begin
                if (car_cnt == '0) begin
                    ir_o    <= ~ir_o;
                    car_cnt <= CAR_LOAD;
                end else begin
                    car_cnt <= car_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_tx.sv
// -----------------------------------------------------------------------------
// tb_nec_ir_tx
//   Directed bench for nec_ir_tx with UNIT_CYCLES=4, GAP_UNITS=16,
//   CARRIER_DIV=2. Expected ir_o waveforms are built cycle by cycle from the
//   NEC frame definition and compared segment by segment; frame lengths and
//   gap behaviour are also checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_nec_ir_tx;

    localparam int U    = 4;
    localparam int GAPU = 16;
    localparam int CDIV = 2;

`ifdef NEC_TX_CARRIER_EN
    localparam bit TB_CARRIER = 1'b1;
`else
    localparam bit TB_CARRIER = 1'b0;
`endif

    // clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       repeat_in = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] command = 8'h00;
    logic       busy_o;
    logic       done_o;
    logic       ir_o;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    nec_ir_tx #(
        .UNIT_CYCLES (U),
        .GAP_UNITS   (GAPU),
        .CARRIER_DIV (CDIV)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .repeat_i  (repeat_in),
        .address_i (address),
        .command_i (command),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ir_o      (ir_o),
        .state_o   (state_o)
    );

    // scoreboard
    logic [0:0] exp_q[$];
    logic [0:0] cap_q[$];
    int         seg_start[$];
    int         seg_len[$];
    int         checks = 0;
    int         passes = 0;

    // Append one mark or space of n units to the expected waveform.
    task automatic add_seg(input bit mark, input int n);
        seg_start.push_back(exp_q.size());
        seg_len.push_back(n * U);
        for (int k = 0; k < n * U; k++) begin
            if (!mark)
                exp_q.push_back(1'b0);
            else if (TB_CARRIER)
                exp_q.push_back(((k / CDIV) % 2) == 0 ? 1'b1 : 1'b0);
            else
                exp_q.push_back(1'b1);
        end
    endtask

    task automatic build_expected(input logic [7:0] addr, input logic [7:0] cmd, input logic rep);
        logic [31:0] word;
        exp_q.delete();
        seg_start.delete();
        seg_len.delete();
        word = {~cmd, cmd, ~addr, addr};
        add_seg(1'b1, 16);
        add_seg(1'b0, rep ? 4 : 8);
        if (!rep) begin
            for (int i = 0; i < 32; i++) begin
                add_seg(1'b1, 1);
                add_seg(1'b0, word[i] ? 3 : 1);
            end
        end
        add_seg(1'b1, 1);
        add_seg(1'b0, GAPU);
    endtask

    // driver: request one transmission, capture ir_o while busy, then score
    task automatic run_tx(input string name, input logic [7:0] addr, input logic [7:0] cmd,
                          input logic rep, input int poke_at, input logic [7:0] poke_cmd,
                          output int busy_len);
        int dones;
        int mism;
        int idx;
        build_expected(addr, cmd, rep);
        @(negedge clk);
        address   = addr;
        command   = cmd;
        repeat_in = rep;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cap_q.delete();
        busy_len = 0;
        dones    = 0;
        while (busy_o === 1'b1 && busy_len < 5000) begin
            cap_q.push_back(ir_o);
            if (done_o === 1'b1) dones++;
            if (busy_len == poke_at) begin
                start   = 1'b1;
                command = poke_cmd;
            end else begin
                start = 1'b0;
            end
            busy_len++;
            @(negedge clk);
        end
        start = 1'b0;
        if (done_o === 1'b1) dones++;
        @(negedge clk);
        if (done_o === 1'b1) dones++;

        checks++;
        if (busy_len !== exp_q.size())
            $display("FAIL %s busy_len: got %0d expected %0d", name, busy_len, exp_q.size());
        else passes++;

        checks++;
        if (dones !== 1)
            $display("FAIL %s done_count: got %0d expected 1", name, dones);
        else passes++;

        for (int s = 0; s < seg_start.size(); s++) begin
            mism = 0;
            for (int k = 0; k < seg_len[s]; k++) begin
                idx = seg_start[s] + k;
                if (idx >= cap_q.size()) mism++;
                else if (cap_q[idx] !== exp_q[idx]) mism++;
            end
            checks++;
            if (mism !== 0)
                $display("FAIL %s seg%0d ir_o: %0d wrong cycles of %0d expected 0", name, s, mism, seg_len[s]);
            else passes++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, ir_o, state_o} !== 6'b000_000)
            $display("FAIL reset_outputs: got busy=%b done=%b ir=%b state=%0d expected all 0",
                     busy_o, done_o, ir_o, state_o);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, done_o, ir_o} !== 3'b000)
            $display("FAIL idle_after_reset: got busy=%b done=%b ir=%b expected 0", busy_o, done_o, ir_o);
        else passes++;
    endtask

    task automatic test_full_frame();
        int blen;
        run_tx("full_frame", 8'h00, 8'h68, 1'b0, -1, 8'h00, blen);
        checks++;
        if (blen !== 548)
            $display("FAIL full_frame_137T: got %0d expected 548", blen);
        else passes++;
    endtask

    task automatic test_repeat_code();
        int blen;
        run_tx("repeat_code", 8'h00, 8'h68, 1'b1, -1, 8'h00, blen);
        checks++;
        if (blen !== 148)
            $display("FAIL repeat_37T: got %0d expected 148", blen);
        else passes++;
    endtask

    task automatic test_start_while_busy();
        int blen;
        run_tx("start_while_busy", 8'h00, 8'h68, 1'b0, 100, 8'hA8, blen);
    endtask

    task automatic test_reset_mid_frame();
        int blen;
        int waited;
        int dones;
        // reset during the lead mark: ir_o must drop without a clock edge
        @(negedge clk);
        address = 8'h12; command = 8'h34; repeat_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ir_o, busy_o} !== 2'b00)
            $display("FAIL async_reset_lead_mark: got ir=%b busy=%b expected 0 0", ir_o, busy_o);
        else passes++;
        @(negedge clk);
        rst = 1'b0;

        // reset during a bit space
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (state_o !== 3'd4 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (state_o !== 3'd4)
            $display("FAIL reach_bit_space: got state %0d expected 4", state_o);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ir_o, busy_o, state_o} !== 5'b00_000)
            $display("FAIL async_reset_bit_space: got ir=%b busy=%b state=%0d expected 0 0 0",
                     ir_o, busy_o, state_o);
        else passes++;
        dones = 0;
        @(negedge clk);
        if (done_o === 1'b1) dones++;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0)
            $display("FAIL no_done_after_reset: got %0d done/busy cycles expected 0", dones);
        else passes++;
        run_tx("after_reset", 8'h5A, 8'h3C, 1'b0, -1, 8'h00, blen);
    endtask

    task automatic test_back_to_back();
        logic [0:0] b_q[$];
        int runs[$];
        int run_len;
        int dones;
        int waited;
        @(negedge clk);
        address = 8'h00; command = 8'h68; repeat_in = 1'b0; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            b_q.push_back(busy_o);
            if (done_o === 1'b1) dones++;
        end
        start = 1'b0;
        run_len = 1;
        for (int i = 1; i < b_q.size(); i++) begin
            if (b_q[i] === b_q[i-1]) run_len++;
            else begin
                runs.push_back(run_len);
                run_len = 1;
            end
        end
        runs.push_back(run_len);
        checks++;
        if (b_q[0] !== 1'b1 || runs.size() < 5)
            $display("FAIL b2b_shape: got first busy=%b runs=%0d expected 1 and >=5", b_q[0], runs.size());
        else passes++;
        if (runs.size() >= 4) begin
            checks++;
            if (runs[0] !== 548 || runs[2] !== 548)
                $display("FAIL b2b_frame_len: got %0d/%0d expected 548/548", runs[0], runs[2]);
            else passes++;
            checks++;
            if (runs[1] !== 1 || runs[3] !== 1)
                $display("FAIL b2b_idle_gap: got %0d/%0d expected 1/1", runs[1], runs[3]);
            else passes++;
        end
        checks++;
        if (dones !== 2)
            $display("FAIL b2b_done_count: got %0d expected 2", dones);
        else passes++;
        waited = 0;
        while (busy_o === 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (busy_o !== 1'b0)
            $display("FAIL b2b_drain: got busy=%b expected 0", busy_o);
        else passes++;
        @(negedge clk);
    endtask

`ifdef NEC_TX_CARRIER_EN
    task automatic test_carrier();
        int blen;
        run_tx("carrier_repeat", 8'h00, 8'h00, 1'b1, -1, 8'h00, blen);
        run_tx("carrier_frame", 8'hC3, 8'h81, 1'b0, -1, 8'h00, blen);
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_repeat_code();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef NEC_TX_CARRIER_EN
        test_carrier();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
